mult_div_unit: RTL and testbench

Sequential signed 32-bit multiply/divide unit for the multicycle MIPS datapath.
- Consumes the one-hot `mult_ctrl` / `div_ctrl` request levels produced by the control-side mult/div decoder.
- Runs a radix-2 Booth multiply or a restoring divide over 32 iterations.
- Writes the HI/LO result registers and pulses `done` back to the control unit.

---
 rtl/mult_div_pkg.sv | 24 ++
 rtl/mult_div_unit_sdiv_core.sv | 59 +++++
 rtl/mult_div_unit.sv | 131 +++++++++++++
 tb/tb_mult_div_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared types and constants for the sequential mult/div unit.
// No logic here: state codes, iteration count and the request-level record.
package mult_div_pkg;

  localparam int ITERS = 32;
  localparam int CNT_W = 5;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t MUL  = 2'd1;
  localparam state_t DIV  = 2'd2;
  localparam state_t FIN  = 2'd3;

  typedef struct packed {
    logic mult;
    logic div;
  } req_t;

  // Two's-complement magnitude; 0x80000000 maps to 2^31 read as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_sdiv_core.sv
// Signed 32-bit divide datapath: one restoring step per 'step' cycle, sign fix-up on output.
// Latency: 32 steps after 'load'. No backpressure; sequenced entirely by the parent FSM.
// Results are valid only after the 32nd step and until the next load.
module sdiv_core
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH:0]   dmag_q;
  logic             q_neg_q;
  logic             r_neg_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Partial remainder stays below the divisor (<= 2^31), so 32 bits of
  // difference are exact whenever the subtract is taken.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    ge      = (shifted >= dmag_q);
    diff    = shifted[WIDTH-1:0] - dmag_q[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q   <= '0;
      rem_q   <= '0;
      dmag_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (load) begin
      quo_q   <= abs32(a);
      rem_q   <= '0;
      dmag_q  <= {1'b0, abs32(b)};
      q_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
      r_neg_q <= a[WIDTH-1];
    end else if (step) begin
      quo_q <= {quo_q[WIDTH-2:0], ge};
      rem_q <= ge ? diff : shifted[WIDTH-1:0];
    end
  end

  assign quotient  = q_neg_q ? (WIDTH'(0) - quo_q) : quo_q;
  assign remainder = r_neg_q ? (WIDTH'(0) - rem_q) : rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed 32x32 Booth multiply / restoring divide writing HI/LO.
// Latency: done 33 edges after the start edge (1 edge for divide by zero).
// No queuing: start edges seen while busy are dropped; busy tells control to wait.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_ctrl,
  input  logic             div_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  state_t           state;
  req_t             req_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_a;
  logic [WIDTH-1:0] acc_q;
  logic             acc_q1;
  logic [WIDTH-1:0] mcand;
  logic             op_mul_q;
  logic             dz_q;

  logic             mul_start;
  logic             div_start;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  // Both levels high at once is an illegal decode and starts nothing.
  assign mul_start = (state == IDLE) && mult_ctrl && !div_ctrl && !req_q.mult;
  assign div_start = (state == IDLE) && div_ctrl && !mult_ctrl && !req_q.div;
  assign busy      = (state != IDLE);

  // 33-bit add keeps A - 0x80000000 from overflowing.
  always_comb begin
    booth_sum = {acc_a[WIDTH-1], acc_a};
    case ({acc_q[0], acc_q1})
      2'b01:   booth_sum = {acc_a[WIDTH-1], acc_a} + {mcand[WIDTH-1], mcand};
      2'b10:   booth_sum = {acc_a[WIDTH-1], acc_a} - {mcand[WIDTH-1], mcand};
      default: booth_sum = {acc_a[WIDTH-1], acc_a};
    endcase
  end

  sdiv_core #(.WIDTH(WIDTH)) u_sdiv_core (
    .clk       (clk),
    .reset     (reset),
    .load      (div_start),
    .step      (state == DIV),
    .a         (a),
    .b         (b),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      req_q    <= req_t'(2'b11);
      cnt      <= '0;
      acc_a    <= '0;
      acc_q    <= '0;
      acc_q1   <= 1'b0;
      mcand    <= '0;
      op_mul_q <= 1'b0;
      dz_q     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      req_q <= '{mult: mult_ctrl, div: div_ctrl};
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (mul_start) begin
            acc_a    <= '0;
            acc_q    <= a;
            acc_q1   <= 1'b0;
            mcand    <= b;
            cnt      <= '0;
            op_mul_q <= 1'b1;
            dz_q     <= 1'b0;
            div_zero <= 1'b0;
            state    <= MUL;
          end else if (div_start) begin
            cnt      <= '0;
            op_mul_q <= 1'b0;
            dz_q     <= (b == '0);
            div_zero <= 1'b0;
            state    <= (b == '0) ? FIN : DIV;
          end
        end
        MUL: begin
          acc_a  <= booth_sum[WIDTH:1];
          acc_q  <= {booth_sum[0], acc_q[WIDTH-1:1]};
          acc_q1 <= acc_q[0];
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(ITERS - 1)) state <= FIN;
        end
        DIV: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(ITERS - 1)) state <= FIN;
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
          if (dz_q) begin
            div_zero <= 1'b1;
          end else if (op_mul_q) begin
            hi <= acc_a;
            lo <= acc_q;
          end else begin
            hi <= div_rem;
            lo <= div_quo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed + randomized bench for mult_div_unit against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        mult_ctrl;
  logic        div_ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int n_cmp;
  int n_err;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .mult_ctrl (mult_ctrl),
    .div_ctrl  (div_ctrl),
    .a         (a),
    .b         (b),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: full signed product, or truncating signed divide in 64-bit math.
  task automatic model(input logic is_div, input logic [31:0] op_a, input logic [31:0] op_b,
                       output logic dz, output int lat);
    longint pa, pb, p, q, r;
    pa = longint'($signed(op_a));
    pb = longint'($signed(op_b));
    dz  = 1'b0;
    lat = 33;
    if (!is_div) begin
      p = pa * pb;
      exp_hi = p[63:32];
      exp_lo = p[31:0];
    end else if (op_b == 32'd0) begin
      dz  = 1'b1;
      lat = 1;
    end else begin
      q = pa / pb;
      r = pa % pb;
      exp_lo = q[31:0];
      exp_hi = r[31:0];
    end
  endtask

  task automatic run_op(input logic is_div, input logic [31:0] op_a, input logic [31:0] op_b,
                        input string tag);
    int   cyc;
    int   lat;
    logic dz;
    logic busy_ok;
    mult_ctrl = 1'b0;
    div_ctrl  = 1'b0;
    tick();
    a = op_a;
    b = op_b;
    if (is_div) div_ctrl = 1'b1;
    else        mult_ctrl = 1'b1;
    tick();  // E0
    check({tag, "_busy_e0"}, 64'(busy), 64'(1));
    check({tag, "_dz_clr"}, 64'(div_zero), 64'(0));
    mult_ctrl = 1'b0;
    div_ctrl  = 1'b0;
    a = $urandom;
    b = $urandom;
    model(is_div, op_a, op_b, dz, lat);
    cyc = 0;
    busy_ok = 1'b1;
    while (cyc < 100) begin
      tick();
      cyc++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_busy_held"}, 64'(busy_ok), 64'(1));
    check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    check({tag, "_div_zero"}, 64'(div_zero), 64'(dz));
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'(0));
    check({tag, "_dz_hold"}, 64'(div_zero), 64'(dz));
  endtask

  initial begin
    int          n_done;
    logic        rdiv;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        dz;
    int          lat;
    n_cmp = 0;
    n_err = 0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;

    // Reset with a request level held high throughout.
    reset = 1'b1;
    mult_ctrl = 1'b1;
    div_ctrl = 1'b0;
    a = 32'd3;
    b = 32'd4;
    repeat (3) tick();
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dz", 64'(div_zero), 64'(0));
    reset = 1'b0;
    repeat (3) tick();
    check("held_over_reset_busy", 64'(busy), 64'(0));
    mult_ctrl = 1'b0;

    // Directed operations.
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, "mul_7x-3");
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, "mul_min_sq");
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, "div_-7/2");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min/-1");
    run_op(1'b0, 32'h1234_5678, 32'h0FED_CBA9, "mul_preload");
    run_op(1'b1, 32'd5, 32'd0, "div_by_zero");
    run_op(1'b0, 32'hFFFF_FF00, 32'd3, "mul_after_dz");

    // Held multiply request with a stray divide pulse while busy.
    n_done = 0;
    a = 32'd1000;
    b = 32'hFFFF_FF9C;
    mult_ctrl = 1'b1;
    for (int i = 0; i < 50; i++) begin
      div_ctrl = (i == 10);
      tick();
      if (done) n_done++;
    end
    div_ctrl = 1'b0;
    mult_ctrl = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) n_done++;
    end
    model(1'b0, 32'd1000, 32'hFFFF_FF9C, dz, lat);
    check("held_done_count", 64'(n_done), 64'(1));
    check("held_hi", 64'(hi), 64'(exp_hi));
    check("held_lo", 64'(lo), 64'(exp_lo));

    // Reset at E10 of a multiply whose request stays high.
    a = 32'd123;
    b = 32'hFFFF_FE38;
    mult_ctrl = 1'b1;
    tick();             // E0
    repeat (9) tick();  // E1..E9
    reset = 1'b1;
    tick();             // E10
    reset = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    check("midrst_hi", 64'(hi), 64'(0));
    check("midrst_lo", 64'(lo), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) n_done++;
    end
    check("midrst_no_restart", 64'(n_done), 64'(0));
    run_op(1'b0, 32'd123, 32'hFFFF_FE38, "mul_restart");

    // Randomized mix, including zero divisors and extreme operands.
    for (int i = 0; i < 16; i++) begin
      rdiv = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'($urandom_range(1, 9));
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(rdiv, ra, rb, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
